mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream channel among eight valid/ready requesters. Picks one requester per burst, drives the 3-bit select of the team's 8-to-1 data mux, and registers the selected beat into a single output stage with its source index. Sits between eight producer ports and any single-consumer datapath (bus bridge, shared ALU, FIFO write port).

---
 rtl/mux8_arb_pkg.sv | 27 ++
 rtl/mux_8to1.sv | 32 +++
 rtl/mux8_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared types and the round-robin pick function for the 8-way arbiter.
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SRC_W   = 3;

  typedef enum logic {IDLE, BURST} arb_state_e;

  // Returns the first index with valid set, starting at ptr and wrapping mod 8.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [SRC_W-1:0]   ptr);
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SRC_W'(k);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Combinational 8-to-1 data mux, one WIDTH-bit lane per input.
module mux_8to1 #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      3'd7: y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Burst-locked round-robin arbiter: eight valid/ready producers share one
// registered output stage that carries the beat's source index.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready
);

  arb_state_e       state_reg, state_next;
  logic [SRC_W-1:0] gnt_reg, gnt_next;
  logic [SRC_W-1:0] ptr_reg, ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;
  logic [SRC_W-1:0] out_src_reg;

  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             xfer;

  mux_8to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (gnt_reg),
    .d0  (req_data[0]),
    .d1  (req_data[1]),
    .d2  (req_data[2]),
    .d3  (req_data[3]),
    .d4  (req_data[4]),
    .d5  (req_data[5]),
    .d6  (req_data[6]),
    .d7  (req_data[7]),
    .y   (sel_data)
  );

  // The output stage can take a beat when empty or draining this cycle.
  assign can_load = !out_valid_reg || out_ready;
  assign xfer     = (state_reg == BURST) && req_valid[gnt_reg] && can_load;

  // req_ready depends only on registered state and out_ready, never on req_valid.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == BURST) && (gnt_reg == SRC_W'(gi)) && can_load;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          gnt_next   = rr_pick(req_valid, ptr_reg);
          state_next = BURST;
        end
      end
      BURST: begin
        if (xfer && req_last[gnt_reg]) begin
          ptr_next   = gnt_reg + SRC_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_last_reg  <= req_last[gnt_reg];
      out_src_reg   <= gnt_reg;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [7:0]            req_valid;
  logic [7:0]            req_last;
  logic [7:0][31:0]      req_data;
  logic [7:0]            req_ready;
  logic                  out_valid;
  logic [31:0]           out_data;
  logic                  out_last;
  logic [2:0]            out_src;
  logic                  out_ready;

  int n_vec = 0;
  int n_err = 0;

  mux8_rr_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [2:0] src, input logic [31:0] data,
                      input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_src"},   32'(out_src),   32'(src));
    chk({tag, "_data"},  out_data,       data);
    chk({tag, "_last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Single requester, three-beat burst.
    req_valid = 8'h04; req_data[2] = 32'hA0;
    step();
    chk("s1_ready", 32'(req_ready), 32'h04);
    step();
    beat("s1_b0", 3'd2, 32'hA0, 1'b0);
    req_data[2] = 32'hA1;
    step();
    beat("s1_b1", 3'd2, 32'hA1, 1'b0);
    req_data[2] = 32'hA2; req_last = 8'h04;
    step();
    beat("s1_b2", 3'd2, 32'hA2, 1'b1);
    chk("s1_ptr", 32'(dut.ptr_reg), 32'd3);
    req_valid = '0;
    step();
    chk("s1_drain", 32'(out_valid), 32'd0);

    // All requesting single-beat bursts from reset: 0,1,...,7,0.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_valid = 8'hFF; req_last = 8'hFF;
    for (int i = 0; i < 8; i++) req_data[i] = 32'h10 + 32'(i);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_ready", 32'(req_ready), 32'(8'h01 << (k % 8)));
      step();
      chk("rr_src", 32'(out_src), 32'(k % 8));
    end

    // Wrap: move ptr to 7, then 0x81 grants 7 then 0.
    req_valid = 8'h40;
    step();
    chk("w_ready6", 32'(req_ready), 32'h40);
    step();
    chk("w_ptr7", 32'(dut.ptr_reg), 32'd7);
    req_valid = 8'h81;
    step();
    chk("w_ready7", 32'(req_ready), 32'h80);
    step();
    beat("w_b7", 3'd7, 32'h17, 1'b1);
    chk("w_ptr0", 32'(dut.ptr_reg), 32'd0);
    step();
    chk("w_ready0", 32'(req_ready), 32'h01);
    step();
    beat("w_b0", 3'd0, 32'h10, 1'b1);
    chk("w_ptr1", 32'(dut.ptr_reg), 32'd1);

    // Backpressure on requester 3.
    req_valid = 8'h08; req_last = 8'h00; req_data[3] = 32'h30;
    step();
    chk("bp_ready", 32'(req_ready), 32'h08);
    step();
    beat("bp_b0", 3'd3, 32'h30, 1'b0);
    out_ready = 1'b0; req_data[3] = 32'h31;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_stall_ready", 32'(req_ready), 32'h00);
      step();
      beat("bp_hold", 3'd3, 32'h30, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h08);
    step();
    beat("bp_b1", 3'd3, 32'h31, 1'b0);
    req_data[3] = 32'h32; req_last = 8'h08;
    step();
    beat("bp_b2", 3'd3, 32'h32, 1'b1);
    req_valid = '0;
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Burst lock on requester 1 while requester 0 waits.
    req_valid = 8'h02; req_last = 8'h00; req_data[1] = 32'h50;
    step();
    chk("bl_ready", 32'(req_ready), 32'h02);
    step();
    beat("bl_b0", 3'd1, 32'h50, 1'b0);
    req_valid = 8'h03; req_data[1] = 32'h51; req_data[0] = 32'h05;
    step();
    beat("bl_b1", 3'd1, 32'h51, 1'b0);
    req_valid = 8'h01;
    step();
    chk("bl_gap_valid", 32'(out_valid), 32'd0);
    chk("bl_gap_ready", 32'(req_ready), 32'h02);
    step();
    chk("bl_gap2_ready", 32'(req_ready), 32'h02);
    req_valid = 8'h03; req_data[1] = 32'h52; req_last = 8'h03;
    step();
    beat("bl_b2", 3'd1, 32'h52, 1'b1);
    req_valid = 8'h01;
    step();
    chk("bl_ready0", 32'(req_ready), 32'h01);
    step();
    beat("bl_r0", 3'd0, 32'h05, 1'b1);

    // Reset mid-burst on requester 2.
    req_valid = 8'h04; req_last = 8'h00; req_data[2] = 32'hC0;
    step();
    step();
    beat("mr_b0", 3'd2, 32'hC0, 1'b0);
    req_data[2] = 32'hC1; req_valid = 8'h05;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data",  out_data,       32'd0);
    chk("mr_out_src",   32'(out_src),   32'd0);
    chk("mr_out_last",  32'(out_last),  32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_ptr",       32'(dut.ptr_reg), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("mr_ready0", 32'(req_ready), 32'h01);
    step();
    chk("mr_src0", 32'(out_src), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
